matmul_stream_engine: RTL and testbench
=======================================

Name: matmul_stream_engine

Overview:
Parametrised serial-load matrix multiply engine, successor to the fixed 4-bit / 3x3 datapath. It computes C = W x X, with dimensions programmed per job up to MAX_DIM. Operands stream in row-major over a valid/ready input port: all of W, then all of X. Results stream out row-major over a valid/ready output port with a last flag. The block sits between the host load interface and the result sink, and replaces the fixed datapath in the accelerator.

Parameters:
DATA_W, 4, operand element width (unsigned).
MAX_DIM, 4, maximum rows/cols of any matrix; W and X storage are each MAX_DIM*MAX_DIM entries.
ACC_W, 10, accumulator and result width.
DIM_W (localparam), $clog2(MAX_DIM+1), dimension field width.

Ports:
clk  in  1  clock, rising edge.
clear_mem  in  1  asynchronous active-high reset; aborts any job.
start  in  1  job request; sampled only in IDLE.
row_w  in  DIM_W  rows of W.
col_w  in  DIM_W  cols of W.
row_x  in  DIM_W  rows of X.
col_x  in  DIM_W  cols of X.
data_in  in  DATA_W  operand element.
in_valid  in  1  data_in valid.
in_ready  out  1  engine accepts data_in.
res  out  ACC_W  result element C[i][j].
res_valid  out  1  res valid.
res_ready  in  1  sink accepts res.
res_last  out  1  res is C[row_w-1][col_x-1].
busy  out  1  job in progress.
dim_err  out  1  last start was rejected.

Behaviour:
- One clock (clk). clear_mem is asynchronous, active-high. Reset values: state=IDLE, in_ready=0, res=0, res_valid=0, res_last=0, busy=0, dim_err=0, all counters=0. Storage contents are don't-care; no unwritten entry is ever read.
- States:
  - IDLE: in_ready=0, busy=0.
  - start=1 in IDLE latches all four dims.
    - Reject if any dim is 0, any dim > MAX_DIM, or col_w != row_x. On reject: dim_err=1, stay IDLE.
    - Otherwise: dim_err=0, busy=1, go to LOAD_W.
  - dim_err is held until the next start is sampled. start while busy is ignored.
  - LOAD_W: in_ready=1 (combinational from state). Each in_valid&&in_ready beat writes W[r][c] row-major. After row_w*col_w beats go to LOAD_X. There are no gaps between the W and X streams other than those the source inserts.
  - LOAD_X: same, row_x*col_x beats written row-major into X[r][c], then go to COMPUTE. in_ready=0 from the cycle after the last X beat.
  - COMPUTE: for the current (i,j), one MAC per cycle: acc += W[i][k]*X[k][j], k=0..col_w-1. The accumulator is cleared on COMPUTE entry. After the k=col_w-1 MAC: register res=acc, res_valid=1, res_last=(i==row_w-1 && j==col_x-1), go to OUTPUT.
  - OUTPUT: res, res_valid and res_last are held stable until res_ready=1.
    - On handshake: res_valid=0 and res_last=0 next cycle.
    - If last: go to IDLE, busy=0.
    - Else advance j (wrapping to 0 and incrementing i when j==col_x-1) and return to COMPUTE.
- Latency:
  - First res_valid appears col_w+1 cycles after the final X beat.
  - With res_ready tied high, consecutive results are col_w+1 cycles apart.
- Arithmetic:
  - Unsigned. Products are 2*DATA_W bits, zero-extended to ACC_W.
  - The accumulator wraps modulo 2^ACC_W (default build).
- in_valid outside LOAD_W/LOAD_X is ignored; no write occurs.
- clear_mem mid-job (any state) returns immediately to the reset values. The next job requires a new start.
- Dims are captured only at start; dim inputs may change freely during a job.

Optional Feature:
Macro: MATMUL_SATURATE_EN.
- Defined: each accumulate step saturates at 2^ACC_W-1 instead of wrapping. Once saturated, the element stays at max for the rest of its k loop. Output behaviour is otherwise identical.
- Undefined: modulo wrap as in Behaviour. No saturation logic is synthesised.

Test Plan:
- 3x2 x 2x3: W=[1 3;4 5;6 7], X=[8 9 10;11 12 13], res_ready=1 -> res sequence 41,45,49,87,96,105,125,138,151; res_last only on 151; busy drops the cycle after.
- 1x1: W=10, X=15 -> single res=150 with res_last=1. 2x2: W=identity, X=[2 3;4 5] -> 2,3,4,5.
- Reject cases:
  - start with col_w=2, row_x=3 -> dim_err=1, in_ready stays 0, busy=0.
  - A following valid start -> dim_err=0.
  - Dim 0 or 5 (MAX_DIM=4) is also rejected.
- Backpressure: in the 3x2 case, hold res_ready=0 for 5 cycles on the 2nd result -> res=45 held stable with res_valid=1. Sequence unchanged; no result lost or repeated.
- Input gaps and reset:
  - Toggle in_valid 1-0-1 during the load -> results identical to the gapless run.
  - Pulse clear_mem mid LOAD_X -> all outputs return to reset values and no res_valid follows.
- ACC_W=8, 1x2 x 2x1, all elements 15 (sum 450):
  - Default build -> res=194.
  - With MATMUL_SATURATE_EN -> res=255.

Source files
------------

// File: rtl/matmul_stream_engine.sv
// ---------------------------------------------------------------------------
// matmul_stream_engine
//   Serial-load matrix multiply engine: C = W x X, with dimensions programmed
//   per job up to MAX_DIM. W then X stream in row-major over a valid/ready
//   input. Results stream out row-major over a valid/ready output, with a
//   last flag on C[row_w-1][col_x-1].
//
// Ports
//   clk        in   rising-edge clock
//   clear_mem  in   asynchronous active-high reset; aborts any job
//   start      in   job request, sampled only while idle
//   row_w, col_w, row_x, col_x  in  job dimensions, captured at start
//   data_in    in   operand element (unsigned)
//   in_valid   in   data_in valid
//   in_ready   out  engine accepts data_in (high while loading W or X)
//   res        out  result element C[i][j]
//   res_valid  out  res valid
//   res_ready  in   sink accepts res
//   res_last   out  res is the final element of the job
//   busy       out  job in progress
//   dim_err    out  the most recent start was rejected
//
// Build option
//   MATMUL_SATURATE_EN : accumulator saturates at 2^ACC_W-1 instead of
//                        wrapping modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module matmul_stream_engine #(
  parameter  int DATA_W  = 4,
  parameter  int MAX_DIM = 4,
  parameter  int ACC_W   = 10,
  localparam int DIM_W   = $clog2(MAX_DIM + 1)
) (
  input  logic              clk,
  input  logic              clear_mem,
  input  logic              start,
  input  logic [DIM_W-1:0]  row_w,
  input  logic [DIM_W-1:0]  col_w,
  input  logic [DIM_W-1:0]  row_x,
  input  logic [DIM_W-1:0]  col_x,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_last,
  output logic              busy,
  output logic              dim_err
);

  localparam int IDX_W  = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_X,
    S_COMPUTE,
    S_OUTPUT
  } state_t;

  state_t state, state_nxt;

  // Job dimensions as captured at start
  logic [DIM_W-1:0] rw, cw, rx, cx;
  // Load position (r,c), output position (i,j), inner-product index k
  logic [DIM_W-1:0] r, c, i, j, k;
  logic [ACC_W-1:0] acc;

  logic [DATA_W-1:0] w_mem [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] x_mem [MAX_DIM][MAX_DIM];

  logic              dims_ok;
  logic              beat;
  logic [DIM_W-1:0]  ld_rows, ld_cols;
  logic              ld_last, w_done, x_done, k_done, out_hs;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  mac;

  // Counters never exceed MAX_DIM-1, so the low bits address the arrays.
  function automatic logic [IDX_W-1:0] idx(input logic [DIM_W-1:0] v);
    return v[IDX_W-1:0];
  endfunction

  // One accumulate step: wraps modulo 2^ACC_W, or clamps at all-ones when
  // saturation is built in. Products are non-negative, so a clamped
  // accumulator stays at max for the rest of its k loop.
  function automatic logic [ACC_W-1:0] acc_step(input logic [ACC_W-1:0]  a,
                                                input logic [PROD_W-1:0] p);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(p);
`ifdef MATMUL_SATURATE_EN
    if (s > SUM_W'({ACC_W{1'b1}})) begin
      return {ACC_W{1'b1}};
    end
`endif
    return s[ACC_W-1:0];
  endfunction

  assign dims_ok = (row_w != '0) && (col_w != '0) && (row_x != '0) && (col_x != '0) &&
                   (row_w <= MAX_D) && (col_w <= MAX_D) &&
                   (row_x <= MAX_D) && (col_x <= MAX_D) &&
                   (col_w == row_x);

  assign in_ready = (state == S_LOAD_W) || (state == S_LOAD_X);
  assign busy     = (state != S_IDLE);
  assign beat     = in_valid && in_ready;

  // Both load phases share one row/col walker; only the limits differ.
  assign ld_rows = (state == S_LOAD_X) ? rx : rw;
  assign ld_cols = (state == S_LOAD_X) ? cx : cw;
  assign ld_last = beat && (r == ld_rows - ONE) && (c == ld_cols - ONE);
  assign w_done  = ld_last && (state == S_LOAD_W);
  assign x_done  = ld_last && (state == S_LOAD_X);
  assign k_done  = (state == S_COMPUTE) && (k == cw - ONE);
  assign out_hs  = (state == S_OUTPUT) && res_ready;

  assign prod = PROD_W'(w_mem[idx(i)][idx(k)]) * PROD_W'(x_mem[idx(k)][idx(j)]);
  assign mac  = acc_step(acc, prod);

  always_ff @(posedge clk or posedge clear_mem) begin
    if (clear_mem) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start && dims_ok) state_nxt = S_LOAD_W;
      S_LOAD_W:  if (w_done)           state_nxt = S_LOAD_X;
      S_LOAD_X:  if (x_done)           state_nxt = S_COMPUTE;
      S_COMPUTE: if (k_done)           state_nxt = S_OUTPUT;
      S_OUTPUT:  if (out_hs)           state_nxt = res_last ? S_IDLE : S_COMPUTE;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear_mem) begin
    if (clear_mem) begin
      rw        <= '0;
      cw        <= '0;
      rx        <= '0;
      cx        <= '0;
      r         <= '0;
      c         <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      acc       <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      dim_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rw      <= row_w;
            cw      <= col_w;
            rx      <= row_x;
            cx      <= col_x;
            dim_err <= !dims_ok;
            r       <= '0;
            c       <= '0;
          end
        end
        S_LOAD_W, S_LOAD_X: begin
          if (beat) begin
            if (c == ld_cols - ONE) begin
              c <= '0;
              r <= (r == ld_rows - ONE) ? '0 : r + ONE;
            end else begin
              c <= c + ONE;
            end
          end
          if (x_done) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            acc <= '0;
          end
        end
        S_COMPUTE: begin
          // The final MAC goes straight into res so the result is visible
          // the cycle after the last product.
          if (k_done) begin
            res       <= mac;
            res_valid <= 1'b1;
            res_last  <= (i == rw - ONE) && (j == cx - ONE);
            k         <= '0;
          end else begin
            acc <= mac;
            k   <= k + ONE;
          end
        end
        S_OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            if (!res_last) begin
              acc <= '0;
              if (j == cx - ONE) begin
                j <= '0;
                i <= i + ONE;
              end else begin
                j <= j + ONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Operand storage carries no reset; only written entries are ever read.
  always_ff @(posedge clk) begin
    if (beat && (state == S_LOAD_W)) w_mem[idx(r)][idx(c)] <= data_in;
    if (beat && (state == S_LOAD_X)) x_mem[idx(r)][idx(c)] <= data_in;
  end

endmodule

// File: tb/tb_matmul_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_matmul_stream_engine
//   Directed bench for matmul_stream_engine. Two instances share all inputs:
//   the default build (ACC_W=10) and a narrow one (ACC_W=8) that exposes
//   accumulator wrap / saturation. A matrix-level model queues the expected
//   result stream per job; one process checks every output handshake.
// ---------------------------------------------------------------------------
module tb_matmul_stream_engine;

  localparam int DATA_W  = 4;
  localparam int MAX_DIM = 4;
  localparam int ACC_W   = 10;
  localparam int DIM_W   = $clog2(MAX_DIM + 1);

  logic              clk = 1'b0;
  logic              clear_mem, start;
  logic [DIM_W-1:0]  row_w, col_w, row_x, col_x;
  logic [DATA_W-1:0] data_in;
  logic              in_valid, res_ready;
  logic              in_ready, res_valid, res_last, busy, dim_err;
  logic [ACC_W-1:0]  res;
  logic              in_ready8, res_valid8, res_last8, busy8, dim_err8;
  logic [7:0]        res8;

  always #5 clk = ~clk;

  matmul_stream_engine #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .clear_mem(clear_mem), .start(start),
    .row_w(row_w), .col_w(col_w), .row_x(row_x), .col_x(col_x),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .res(res), .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last),
    .busy(busy), .dim_err(dim_err)
  );

  matmul_stream_engine #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .ACC_W(8)) u_dut8 (
    .clk(clk), .clear_mem(clear_mem), .start(start),
    .row_w(row_w), .col_w(col_w), .row_x(row_x), .col_x(col_x),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready8),
    .res(res8), .res_valid(res_valid8), .res_ready(res_ready), .res_last(res_last8),
    .busy(busy8), .dim_err(dim_err8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int v10;
    int v8;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   wm[16];
  int   xm[16];

  task automatic model_push(input int rw, input int cw, input int cx);
    exp_t e;
    int   sum;
    for (int ii = 0; ii < rw; ii++) begin
      for (int jj = 0; jj < cx; jj++) begin
        sum = 0;
        for (int kk = 0; kk < cw; kk++) sum += wm[ii*cw + kk] * xm[kk*cx + jj];
        e.v10 = sum % 1024;
`ifdef MATMUL_SATURATE_EN
        e.v8 = (sum > 255) ? 255 : sum;
`else
        e.v8 = sum % 256;
`endif
        e.last = (ii == rw - 1) && (jj == cx - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- compare process ----------------
  int   cyc = 0;
  int   hs_cyc[$];
  int   last_beat_cyc = 0;
  exp_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!clear_mem && (res_valid || res_valid8)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_res_valid", int'(res_valid | res_valid8), 0);
      end else if (res_ready) begin
        cur = exp_q.pop_front();
        chk("res",        int'(res),        cur.v10);
        chk("res_acc8",   int'(res8),       cur.v8);
        chk("res_last",   int'(res_last),   int'(cur.last));
        chk("res_last8",  int'(res_last8),  int'(cur.last));
        chk("res_valid",  int'(res_valid),  1);
        chk("res_valid8", int'(res_valid8), 1);
        hs_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int rw, input int cw, input int rx, input int cx);
    row_w = DIM_W'(rw);
    col_w = DIM_W'(cw);
    row_x = DIM_W'(rx);
    col_x = DIM_W'(cx);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble the dim inputs: the engine must use the captured values.
    row_w = DIM_W'(1);
    col_w = DIM_W'(3);
    row_x = DIM_W'(4);
    col_x = DIM_W'(2);
  endtask

  task automatic load(input int nw, input int nx, input bit gaps);
    for (int b = 0; b < nw + nx; b++) begin
      data_in  = DATA_W'(b < nw ? wm[b] : xm[b - nw]);
      in_valid = 1'b1;
      @(negedge clk);
      chk("in_ready_load", int'(in_ready), 1);
      last_beat_cyc = cyc;
      tick();
      if (gaps && (b % 2 == 0)) begin
        in_valid = 1'b0;
        data_in  = '1;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    @(negedge clk);
    while (!res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("res_valid_timeout", int'(res_valid), 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    chk("job_done_timeout", exp_q.size(), 0);
    exp_q.delete();
    chk("busy_after_last", int'(busy), 0);
  endtask

  task automatic run_job(input int rw, input int cw, input int cx, input bit gaps);
    do_start(rw, cw, cw, cx);
    chk("busy_after_start", int'(busy), 1);
    model_push(rw, cw, cx);
    load(rw*cw, cw*cx, gaps);
    wait_done();
  endtask

  task automatic set_3x2();
    wm = '{1, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    xm = '{8, 9, 10, 11, 12, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rv_cnt;
    clear_mem = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    data_in   = '0;
    row_w = '0; col_w = '0; row_x = '0; col_x = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",      int'(busy),      0);
    chk("rst_in_ready",  int'(in_ready),  0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_last",  int'(res_last),  0);
    chk("rst_res",       int'(res),       0);
    chk("rst_dim_err",   int'(dim_err),   0);
    chk("rst_busy8",     int'(busy8),     0);
    chk("rst_in_ready8", int'(in_ready8), 0);
    chk("rst_dim_err8",  int'(dim_err8),  0);
    clear_mem = 1'b0;
    tick();

    // 3x2 x 2x3, gapless, sink always ready: latency and spacing
    set_3x2();
    hs_cyc.delete();
    do_start(3, 2, 2, 3);
    model_push(3, 2, 3);
    chk("model_c00",   exp_q[0].v10, 41);
    chk("model_c01",   exp_q[1].v10, 45);
    chk("model_c22",   exp_q[8].v10, 151);
    chk("model_last8", int'(exp_q[8].last), 1);
    chk("model_last7", int'(exp_q[7].last), 0);
    load(6, 6, 1'b0);
    wait_valid();
    chk("first_latency", cyc - last_beat_cyc, 3);
    tick();
    wait_done();
    chk("hs_count", hs_cyc.size(), 9);
    for (int n = 1; n < hs_cyc.size(); n++) chk("result_spacing", hs_cyc[n] - hs_cyc[n-1], 3);

    // Same job with source gaps between beats
    run_job(3, 2, 3, 1'b1);

    // 1x1
    wm[0] = 10;
    xm[0] = 15;
    do_start(1, 1, 1, 1);
    model_push(1, 1, 1);
    chk("model_1x1", exp_q[0].v10, 150);
    load(1, 1, 1'b0);
    wait_valid();
    chk("res_1x1",      int'(res),      150);
    chk("res_last_1x1", int'(res_last), 1);
    tick();
    wait_done();

    // Rejected starts
    do_start(2, 2, 3, 3);
    chk("rej_mismatch_dim_err",  int'(dim_err),  1);
    chk("rej_mismatch_busy",     int'(busy),     0);
    chk("rej_mismatch_in_ready", int'(in_ready), 0);
    repeat (3) tick();
    chk("rej_dim_err_held",  int'(dim_err),  1);
    chk("rej_in_ready_held", int'(in_ready), 0);
    do_start(0, 2, 2, 2);
    chk("rej_zero_dim_err", int'(dim_err), 1);
    chk("rej_zero_busy",    int'(busy),    0);
    do_start(5, 1, 1, 1);
    chk("rej_five_dim_err", int'(dim_err), 1);
    chk("rej_five_busy",    int'(busy),    0);

    // Valid start clears dim_err; 2x2 identity; start while busy ignored
    wm = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    xm = '{2, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    do_start(2, 2, 2, 2);
    chk("accept_dim_err", int'(dim_err), 0);
    model_push(2, 2, 2);
    chk("model_id_c11", exp_q[3].v10, 5);
    do_start(2, 2, 3, 3);
    chk("busy_start_ignored_dim_err", int'(dim_err), 0);
    chk("busy_start_ignored_busy",    int'(busy),    1);
    load(4, 4, 1'b0);
    wait_done();

    // Backpressure: second result held for 5 cycles
    set_3x2();
    res_ready = 1'b0;
    do_start(3, 2, 2, 3);
    model_push(3, 2, 3);
    load(6, 6, 1'b0);
    wait_valid();
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    wait_valid();
    for (int h = 0; h < 5; h++) begin
      chk("bp_res_held",   int'(res),       45);
      chk("bp_valid_held", int'(res_valid), 1);
      chk("bp_last_held",  int'(res_last),  0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_done();

    // Narrow accumulator: 1x2 x 2x1, all 15, sum 450
    wm = '{15, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    xm = '{15, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    do_start(1, 2, 2, 1);
    model_push(1, 2, 1);
    chk("model_acc10", exp_q[0].v10, 450);
`ifdef MATMUL_SATURATE_EN
    chk("model_acc8", exp_q[0].v8, 255);
`else
    chk("model_acc8", exp_q[0].v8, 194);
`endif
    load(2, 2, 1'b0);
    wait_valid();
    chk("res_acc10_450", int'(res), 450);
`ifdef MATMUL_SATURATE_EN
    chk("res_acc8_sat", int'(res8), 255);
`else
    chk("res_acc8_wrap", int'(res8), 194);
`endif
    tick();
    wait_done();

    // clear_mem in the middle of LOAD_X
    set_3x2();
    do_start(3, 2, 2, 3);
    load(6, 3, 1'b0);
    chk("pre_clear_busy", int'(busy), 1);
    clear_mem = 1'b1;
    #1;
    chk("clr_busy",      int'(busy),      0);
    chk("clr_in_ready",  int'(in_ready),  0);
    chk("clr_res_valid", int'(res_valid), 0);
    chk("clr_res_last",  int'(res_last),  0);
    chk("clr_res",       int'(res),       0);
    chk("clr_dim_err",   int'(dim_err),   0);
    #2;
    clear_mem = 1'b0;
    in_valid  = 1'b1;
    data_in   = DATA_W'(7);
    rv_cnt    = 0;
    for (int t = 0; t < 25; t++) begin
      tick();
      if (t == 3) in_valid = 1'b0;
      if (res_valid || in_ready || busy) rv_cnt++;
    end
    chk("no_activity_after_clear", rv_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
